vga_timing_ctrl: RTL and testbench

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

---
 rtl/vga_timing_ctrl.sv | 131 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// Free-running VGA raster generator: pixel strobe, H/V counters, sync/enable
// decode, per-line colour band index and a frame-origin pulse.
module vga_timing_ctrl #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int BAND_LINES = 60
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic       PIX_EN,
    output logic [9:0] HCOUNT,
    output logic [9:0] VCOUNT,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic [2:0] BAND,
    output logic       FRAME_START
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam int              LB_W    = (BAND_LINES > 1) ? $clog2(BAND_LINES) : 1;
    localparam logic [LB_W-1:0] LB_LAST = LB_W'(BAND_LINES - 1);

    logic            r_pix_en;
    logic [9:0]      r_hcount;
    logic [9:0]      r_vcount;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic [2:0]      r_band;
    logic            r_frame_start;
    logic [LB_W-1:0] r_line_in_band;
    logic [2:0]      r_band_cnt;

    logic            w_advance;
    logic            w_h_wrap;
    logic            w_v_wrap;
    logic [9:0]      w_hcount_nxt;
    logic [9:0]      w_vcount_nxt;
    logic [LB_W-1:0] w_lib_nxt;
    logic [2:0]      w_band_cnt_nxt;
    logic [2:0]      w_band_nxt;

    // All decoded outputs are computed from the next counter values so they
    // land on the same edge as the counters themselves.
    always_comb begin
        w_advance      = r_pix_en;
        w_h_wrap       = (r_hcount == H_LAST);
        w_v_wrap       = w_h_wrap && (r_vcount == V_LAST);
        w_hcount_nxt   = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
        w_vcount_nxt   = r_vcount;
        w_lib_nxt      = r_line_in_band;
        w_band_cnt_nxt = r_band_cnt;

        if (w_v_wrap) begin
            w_vcount_nxt   = 10'd0;
            w_lib_nxt      = '0;
            w_band_cnt_nxt = 3'd0;
        end else if (w_h_wrap) begin
            w_vcount_nxt = r_vcount + 10'd1;
            if (r_line_in_band == LB_LAST) begin
                w_lib_nxt = '0;
                if (r_band_cnt != 3'd7) begin
                    w_band_cnt_nxt = r_band_cnt + 3'd1;
                end
            end else begin
                w_lib_nxt = r_line_in_band + LB_W'(1);
            end
        end

        w_band_nxt = (w_vcount_nxt < V_VIS) ? w_band_cnt_nxt : 3'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix_en       <= 1'b0;
            r_hcount       <= 10'd0;
            r_vcount       <= 10'd0;
            r_hsync        <= 1'b1;
            r_vsync        <= 1'b1;
            r_de           <= 1'b1;
            r_band         <= 3'd0;
            r_frame_start  <= 1'b0;
            r_line_in_band <= '0;
            r_band_cnt     <= 3'd0;
        end else begin
            r_pix_en      <= ~r_pix_en;
            r_frame_start <= 1'b0;
            if (w_advance) begin
                r_hcount       <= w_hcount_nxt;
                r_vcount       <= w_vcount_nxt;
                r_line_in_band <= w_lib_nxt;
                r_band_cnt     <= w_band_cnt_nxt;
                r_band         <= w_band_nxt;
                r_hsync        <= !((w_hcount_nxt >= HS_START) && (w_hcount_nxt < HS_END));
                r_vsync        <= !((w_vcount_nxt >= VS_START) && (w_vcount_nxt < VS_END));
                r_de           <= (w_hcount_nxt < H_VIS) && (w_vcount_nxt < V_VIS);
                // Only a counted arrival at the origin pulses; reset's (0,0) never does.
                r_frame_start  <= (w_hcount_nxt == 10'd0) && (w_vcount_nxt == 10'd0);
            end
        end
    end

    assign PIX_EN      = r_pix_en;
    assign HCOUNT      = r_hcount;
    assign VCOUNT      = r_vcount;
    assign HSYNC       = r_hsync;
    assign VSYNC       = r_vsync;
    assign DE          = r_de;
    assign BAND        = r_band;
    assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: default geometry, a short-line 525-line
// geometry for whole-frame checks, and a tiny 10x6 geometry.
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    logic rst_c_n = 1'b0;

    logic       a_pe, a_hs, a_vs, a_de, a_fs;
    logic [9:0] a_h, a_v;
    logic [2:0] a_band;
    logic       b_pe, b_hs, b_vs, b_de, b_fs;
    logic [9:0] b_h, b_v;
    logic [2:0] b_band;
    logic       c_pe, c_hs, c_vs, c_de, c_fs;
    logic [9:0] c_h, c_v;
    logic [2:0] c_band;

    vga_timing_ctrl u_dut_a (
        .CLK(clk), .RST_N(rst_a_n), .PIX_EN(a_pe), .HCOUNT(a_h), .VCOUNT(a_v),
        .HSYNC(a_hs), .VSYNC(a_vs), .DE(a_de), .BAND(a_band), .FRAME_START(a_fs)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1)
    ) u_dut_b (
        .CLK(clk), .RST_N(rst_b_n), .PIX_EN(b_pe), .HCOUNT(b_h), .VCOUNT(b_v),
        .HSYNC(b_hs), .VSYNC(b_vs), .DE(b_de), .BAND(b_band), .FRAME_START(b_fs)
    );

    vga_timing_ctrl #(
        .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(0), .V_SYNC(1), .V_BP(1), .BAND_LINES(2)
    ) u_dut_c (
        .CLK(clk), .RST_N(rst_c_n), .PIX_EN(c_pe), .HCOUNT(c_h), .VCOUNT(c_v),
        .HSYNC(c_hs), .VSYNC(c_vs), .DE(c_de), .BAND(c_band), .FRAME_START(c_fs)
    );

    // {PIX_EN, HCOUNT, VCOUNT, HSYNC, VSYNC, DE, BAND, FRAME_START}
    localparam logic [27:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0};

    int n_vec = 0;
    int n_err = 0;
    int c_a   = 0;

    task automatic test_reset();
        logic [27:0] obs;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        repeat (2) @(negedge clk);
        obs = {a_pe, a_h, a_v, a_hs, a_vs, a_de, a_band, a_fs};
        n_vec++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_a: got %h want %h", obs, RESET_VEC); end
        obs = {b_pe, b_h, b_v, b_hs, b_vs, b_de, b_band, b_fs};
        n_vec++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_b: got %h want %h", obs, RESET_VEC); end
        obs = {c_pe, c_h, c_v, c_hs, c_vs, c_de, c_band, c_fs};
        n_vec++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_c: got %h want %h", obs, RESET_VEC); end
    endtask

    task automatic test_startup();
        logic       exp_pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0] exp_h[4]  = '{10'd0, 10'd1, 10'd1, 10'd2};
        rst_a_n = 1'b1;
        c_a = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); c_a++;
            n_vec++;
            if (a_pe !== exp_pe[k] || a_h !== exp_h[k] || a_v !== 10'd0 ||
                a_de !== 1'b1 || a_hs !== 1'b1 || a_fs !== 1'b0) begin
                n_err++;
                $display("FAIL startup[%0d]: got pe=%b h=%0d v=%0d de=%b hs=%b fs=%b want pe=%b h=%0d v=0 de=1 hs=1 fs=0",
                         k, a_pe, a_h, a_v, a_de, a_hs, a_fs, exp_pe[k], exp_h[k]);
            end
        end
    endtask

    task automatic test_hsync();
        int   h;
        int   hs_fall = -1, hs_rise = -1, de_fall = -1;
        logic prev_hs = 1'b1, prev_de = 1'b1;
        logic [9:0] eh;
        logic ehs, ede;
        while (c_a < 1520) begin
            @(negedge clk); c_a++;
            h   = (c_a / 2) % 800;
            eh  = 10'(h);
            ehs = (h >= 656 && h < 752) ? 1'b0 : 1'b1;
            ede = (h < 640) ? 1'b1 : 1'b0;
            n_vec++;
            if ({a_h, a_v, a_hs, a_de} !== {eh, 10'd0, ehs, ede}) begin
                n_err++;
                $display("FAIL hline c=%0d: got h=%0d v=%0d hs=%b de=%b want h=%0d v=0 hs=%b de=%b",
                         c_a, a_h, a_v, a_hs, a_de, eh, ehs, ede);
            end
            if (prev_hs === 1'b1 && a_hs === 1'b0) hs_fall = c_a;
            if (prev_hs === 1'b0 && a_hs === 1'b1) hs_rise = c_a;
            if (prev_de === 1'b1 && a_de === 1'b0) de_fall = c_a;
            prev_hs = a_hs;
            prev_de = a_de;
        end
        n_vec++;
        if (hs_fall != 1312) begin n_err++; $display("FAIL hsync_fall_cycle: got %0d want 1312", hs_fall); end
        n_vec++;
        if (hs_rise != 1504) begin n_err++; $display("FAIL hsync_rise_cycle: got %0d want 1504", hs_rise); end
        n_vec++;
        if (de_fall != 1280) begin n_err++; $display("FAIL de_fall_cycle: got %0d want 1280", de_fall); end
    endtask

    task automatic test_midframe_reset();
        int pos;
        logic [27:0] obs;
        logic       exp_pe[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [9:0] exp_h[4]  = '{10'd0, 10'd1, 10'd1, 10'd2};
        while (c_a < 5600) begin
            @(negedge clk); c_a++;
            pos = c_a / 2;
            n_vec++;
            if ({a_h, a_v, a_fs} !== {10'(pos % 800), 10'(pos / 800), 1'b0}) begin
                n_err++;
                $display("FAIL run_a c=%0d: got h=%0d v=%0d fs=%b want h=%0d v=%0d fs=0",
                         c_a, a_h, a_v, a_fs, pos % 800, pos / 800);
            end
        end
        n_vec++;
        if (a_h !== 10'd400 || a_v !== 10'd3) begin
            n_err++; $display("FAIL pre_reset_pos: got (%0d,%0d) want (3,400)", a_v, a_h);
        end
        #2 rst_a_n = 1'b0;
        #1;
        obs = {a_pe, a_h, a_v, a_hs, a_vs, a_de, a_band, a_fs};
        n_vec++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL async_reset: got %h want %h", obs, RESET_VEC); end
        @(negedge clk);
        obs = {a_pe, a_h, a_v, a_hs, a_vs, a_de, a_band, a_fs};
        n_vec++;
        if (obs !== RESET_VEC) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, RESET_VEC); end
        rst_a_n = 1'b1;
        c_a = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); c_a++;
            n_vec++;
            if (a_pe !== exp_pe[k] || a_h !== exp_h[k] || a_v !== 10'd0 || a_fs !== 1'b0) begin
                n_err++;
                $display("FAIL restart[%0d]: got pe=%b h=%0d v=%0d fs=%b want pe=%b h=%0d v=0 fs=0",
                         k, a_pe, a_h, a_v, a_fs, exp_pe[k], exp_h[k]);
            end
        end
    endtask

    task automatic test_frame();
        int c = 0, pos, h, v;
        int first_fs = -1, second_fs = -1, vs_low = 0;
        logic [2:0] prev_band = 3'd0;
        logic [27:0] obs, exp_v;
        logic ehs, evs, ede, efs, epe;
        logic [2:0] eband;
        int         chk_line[5] = '{0, 59, 60, 479, 480};
        logic [2:0] chk_band[5] = '{3'd0, 3'd0, 3'd1, 3'd7, 3'd0};
        rst_b_n = 1'b1;
        while (second_fs < 0 && c < 20000) begin
            @(negedge clk); c++;
            pos   = c / 2;
            h     = pos % 8;
            v     = (pos / 8) % 525;
            epe   = (c % 2 == 1);
            ehs   = !(h >= 5 && h < 7);
            evs   = !(v >= 490 && v < 492);
            ede   = (h < 4) && (v < 480);
            eband = (v < 480) ? 3'(v / 60) : 3'd0;
            efs   = (c % 2 == 0) && (pos % 4200 == 0);
            exp_v = {epe, 10'(h), 10'(v), ehs, evs, ede, eband, efs};
            obs   = {b_pe, b_h, b_v, b_hs, b_vs, b_de, b_band, b_fs};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL frame c=%0d: got %h want %h", c, obs, exp_v);
            end
            if (b_fs === 1'b1) begin
                if (first_fs < 0) first_fs = c;
                else second_fs = c;
            end
            if (first_fs >= 0 && second_fs < 0 && b_vs === 1'b0) vs_low++;
            if (b_band !== prev_band) begin
                n_vec++;
                if (b_h !== 10'd0) begin
                    n_err++; $display("FAIL band_edge c=%0d: band changed at h=%0d want h=0", c, b_h);
                end
            end
            prev_band = b_band;
            if (c % 2 == 0 && h == 0 && pos < 4200) begin
                for (int k = 0; k < 5; k++) begin
                    if (v == chk_line[k]) begin
                        n_vec++;
                        if (b_band !== chk_band[k]) begin
                            n_err++;
                            $display("FAIL band_line%0d: got %0d want %0d", chk_line[k], b_band, chk_band[k]);
                        end
                    end
                end
            end
        end
        n_vec++;
        if (second_fs < 0) begin n_err++; $display("FAIL frame_timeout: got %0d pulses want 2", (first_fs >= 0) ? 1 : 0); end
        n_vec++;
        if (first_fs != 8400) begin n_err++; $display("FAIL first_frame_start: got c=%0d want 8400", first_fs); end
        n_vec++;
        if (second_fs - first_fs != 8400) begin
            n_err++; $display("FAIL frame_period: got %0d want 8400", second_fs - first_fs);
        end
        n_vec++;
        if (vs_low != 32) begin n_err++; $display("FAIL vsync_low_cycles: got %0d want 32", vs_low); end
    endtask

    task automatic test_small();
        int pos, h, v, first_fs = -1;
        logic [27:0] obs, exp_v;
        logic ehs, evs, ede, efs, epe;
        logic [2:0] band_tab[6] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
        rst_c_n = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            pos = c / 2;
            h   = pos % 10;
            v   = (pos / 10) % 6;
            epe = (c % 2 == 1);
            ehs = !(h == 7 || h == 8);
            evs = !(v == 4);
            ede = (h < 6) && (v < 4);
            efs = (c % 2 == 0) && (pos % 60 == 0);
            exp_v = {epe, 10'(h), 10'(v), ehs, evs, ede, band_tab[v], efs};
            obs   = {c_pe, c_h, c_v, c_hs, c_vs, c_de, c_band, c_fs};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL small c=%0d: got %h want %h", c, obs, exp_v);
            end
            if (c_fs === 1'b1 && first_fs < 0) first_fs = c;
        end
        n_vec++;
        if (first_fs != 120) begin n_err++; $display("FAIL small_frame_start: got c=%0d want 120", first_fs); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_hsync();
        test_midframe_reset();
        test_frame();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
